// File: rtl/vector_store_unit.sv
// Drains one snapshotted vector register into byte-addressed memory, one element
// per accepted write, under a start/busy/done handshake from the control unit.
module vector_store_unit #(
  parameter int regSize   = 8,
  parameter int vecSize   = 4,
  parameter int selBits   = 2,
  parameter int addrWidth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [selBits-1:0]         src_reg_i,
  input  logic [addrWidth-1:0]       base_addr_i,
  output logic [selBits-1:0]         r_sel_o,
  input  logic [vecSize*regSize-1:0] reg_data_i,
  output logic                       mem_wr_en_o,
  output logic [addrWidth-1:0]       mem_addr_o,
  output logic [regSize-1:0]         mem_wr_data_o,
  input  logic                       mem_ready_i,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int IdxW = (vecSize > 1) ? $clog2(vecSize) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [selBits-1:0]         src_q, src_d;
  logic [addrWidth-1:0]       base_q, base_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [vecSize*regSize-1:0] snap_q, snap_d;
  logic                       wr_en_q, wr_en_d;
  logic [addrWidth-1:0]       addr_q, addr_d;
  logic [regSize-1:0]         data_q, data_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  // Next-state logic; outputs are precomputed from the next state so they leave registers.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    base_d  = base_q;
    idx_d   = idx_q;
    snap_d  = snap_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_reg_i;
          base_d  = base_addr_i;
          idx_d   = '0;
          state_d = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: begin
        snap_d  = reg_data_i;
        state_d = WRITE;
      end
      WRITE: begin
        if (mem_ready_i) begin
          if (idx_q == IdxW'(vecSize - 1)) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          state_d = WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_en_d = (state_d == WRITE);
    busy_d  = (state_d == LATCH) || (state_d == WRITE);
    done_d  = (state_d == DONE);
    // Address and data hold their last value outside WRITE.
    if (state_d == WRITE) begin
      addr_d = base_d + addrWidth'(idx_d);
      data_d = snap_d[int'(idx_d) * regSize +: regSize];
    end else begin
      addr_d = addr_q;
      data_d = data_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign r_sel_o       = src_q;
  assign mem_wr_en_o   = wr_en_q;
  assign mem_addr_o    = addr_q;
  assign mem_wr_data_o = data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_vector_store_unit.sv
// Table-driven bench for vector_store_unit with a small register-file model
// feeding the read port and a stall-capable memory responder.
module tb_vector_store_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  src_reg;
  logic [15:0] base_addr;
  logic [1:0]  r_sel;
  logic [31:0] reg_data;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_ready;
  logic        busy;
  logic        done;

  logic [31:0] rf [4];
  int n_checks = 0;
  int n_fail   = 0;

  vector_store_unit #(
    .regSize(8), .vecSize(4), .selBits(2), .addrWidth(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .src_reg_i(src_reg),
    .base_addr_i(base_addr), .r_sel_o(r_sel), .reg_data_i(reg_data),
    .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data),
    .mem_ready_i(mem_ready), .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb reg_data = rf[r_sel];

  typedef struct {
    logic [1:0]       src;
    logic [15:0]      base;
    logic [31:0]      data;
    int               stall_elem;
    int               stall_cycles;
    bit               corrupt;
    logic [3:0][15:0] exp_addr;
    logic [3:0][7:0]  exp_data;
    int               exp_done_cyc;
    int               exp_busy;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " r_sel"}, 32'(r_sel), 32'd0);
    check({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'd0);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, " mem_wr_data"}, 32'(mem_wr_data), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
  endtask

  // Cycle 1 is the LATCH cycle (the first negedge after the start edge).
  task automatic run_store(input vec_t v, input int id);
    int n_wr = 0, n_done = 0, busy_cnt = 0, wr_cyc = 0, done_cyc = -1;
    int stall_left, conflicts = 0, unstable = 0, rsel_bad = 0;
    logic prev_stall = 1'b0;
    logic [15:0] pa = 16'd0;
    logic [7:0]  pd = 8'd0;
    string tag;
    tag = $sformatf("vec%0d", id);
    rf[v.src] = v.data;
    @(negedge clk);
    start = 1'b1; src_reg = v.src; base_addr = v.base; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; src_reg = ~v.src; base_addr = 16'hAAAA;
    stall_left = v.stall_cycles;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start = 1'b0;
      if (v.corrupt && cyc == 3) begin
        rf[v.src] = 32'h0000_0000;
        start = 1'b1;
        src_reg = 2'd3;
      end
      if (v.corrupt && done) start = 1'b1;
      mem_ready = 1'b1;
      if (mem_wr_en && n_wr == v.stall_elem && stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end
      if (busy && done) conflicts++;
      if (prev_stall && (!mem_wr_en || mem_addr !== pa || mem_wr_data !== pd)) unstable++;
      if (busy) begin
        busy_cnt++;
        if (r_sel !== v.src) rsel_bad++;
      end
      if (mem_wr_en) begin
        wr_cyc++;
        if (mem_ready) begin
          if (n_wr < 4) begin
            check($sformatf("%s addr[%0d]", tag, n_wr), 32'(mem_addr), 32'(v.exp_addr[n_wr]));
            check($sformatf("%s data[%0d]", tag, n_wr), 32'(mem_wr_data), 32'(v.exp_data[n_wr]));
          end
          n_wr++;
        end
      end
      prev_stall = mem_wr_en && !mem_ready;
      pa = mem_addr;
      pd = mem_wr_data;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
    mem_ready = 1'b1;
    check({tag, " write count"}, 32'(n_wr), 32'd4);
    check({tag, " write cycles"}, 32'(wr_cyc), 32'(4 + v.stall_cycles));
    check({tag, " done cycle"}, 32'(done_cyc), 32'(v.exp_done_cyc));
    check({tag, " done count"}, 32'(n_done), 32'd1);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(v.exp_busy));
    check({tag, " busy&done"}, 32'(conflicts), 32'd0);
    check({tag, " stall hold"}, 32'(unstable), 32'd0);
    check({tag, " r_sel"}, 32'(rsel_bad), 32'd0);
  endtask

  initial begin
    int wr_after, done_after, busy_after;

    tbl[0] = '{2'd1, 16'h0040, 32'hDEADBEEF, -1, 0, 1'b0,
               {16'h0043, 16'h0042, 16'h0041, 16'h0040}, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 6, 5};
    tbl[1] = '{2'd3, 16'h1000, 32'h1A2B3C4D, 1, 2, 1'b0,
               {16'h1003, 16'h1002, 16'h1001, 16'h1000}, {8'h1A, 8'h2B, 8'h3C, 8'h4D}, 8, 7};
    tbl[2] = '{2'd1, 16'hFFFE, 32'hDEADBEEF, -1, 0, 1'b0,
               {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 6, 5};
    tbl[3] = '{2'd1, 16'h0200, 32'hDEADBEEF, -1, 0, 1'b1,
               {16'h0203, 16'h0202, 16'h0201, 16'h0200}, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 6, 5};
    tbl[4] = '{2'd2, 16'h7FFF, 32'h01020304, 3, 1, 1'b0,
               {16'h8002, 16'h8001, 16'h8000, 16'h7FFF}, {8'h01, 8'h02, 8'h03, 8'h04}, 7, 6};
    tbl[5] = '{2'd0, 16'h0000, 32'h00FF55AA, 0, 1, 1'b0,
               {16'h0003, 16'h0002, 16'h0001, 16'h0000}, {8'h00, 8'hFF, 8'h55, 8'hAA}, 7, 6};

    rf[0] = 32'h0; rf[1] = 32'h0; rf[2] = 32'h0; rf[3] = 32'h0;
    rst = 1'b1; start = 1'b1; src_reg = 2'd2; base_addr = 16'h1234; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 6; i++) run_store(tbl[i], i);

    // Reset while element 2 is on the bus aborts the store with no done.
    rf[1] = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b1; src_reg = 2'd1; base_addr = 16'h0040;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst presented addr", 32'(mem_addr), 32'h0042);
    check("midrst presented data", 32'(mem_wr_data), 32'hAD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midrst");
    wr_after = 0; done_after = 0; busy_after = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_wr_en) wr_after++;
      if (done) done_after++;
      if (busy) busy_after++;
    end
    check("midrst later writes", 32'(wr_after), 32'd0);
    check("midrst later done", 32'(done_after), 32'd0);
    check("midrst later busy", 32'(busy_after), 32'd0);

    // A fresh store after the abort still works.
    run_store(tbl[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
